// File: rtl/mult_div_issue_queue_pkg.sv
// Shared types for the mult/div issue queue: dispatch payload, CDB bus and default depth.
package mult_div_issue_queue_pkg;

  localparam int unsigned TAG_W_DEF     = 6;
  localparam int unsigned MDQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [31:0]          rs1_data;
    logic                 rs1_data_valid;
    logic [TAG_W_DEF-1:0] rs1_tag;
    logic [31:0]          rs2_data;
    logic                 rs2_data_valid;
    logic [TAG_W_DEF-1:0] rs2_tag;
    logic [TAG_W_DEF-1:0] rd_tag;
  } queue_data;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [31:0]          data;
  } cdb_bus_t;

endpackage

// File: rtl/mult_div_issue_queue_if.sv
// Dispatch, CDB and issue signals between the dispatcher/functional unit side (master)
// and the issue queue (slave).
interface mult_div_issue_queue_if #(
  parameter int unsigned DEPTH = mult_div_issue_queue_pkg::MDQ_DEPTH_DEF
) ();
  import mult_div_issue_queue_pkg::*;

  logic                         dispatch_en;
  queue_data                    dispatch_data;
  logic                         cdb_valid;
  logic [TAG_W_DEF-1:0]         cdb_tag;
  logic [31:0]                  cdb_data;
  logic                         issue_ready;
  logic                         issue_valid;
  queue_data                    issue_data;
  logic                         queue_full;
  logic [$clog2(DEPTH+1)-1:0]   queue_count;

  modport master (
    output dispatch_en, dispatch_data, cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  issue_valid, issue_data, queue_full, queue_count
  );

  modport slave (
    input  dispatch_en, dispatch_data, cdb_valid, cdb_tag, cdb_data, issue_ready,
    output issue_valid, issue_data, queue_full, queue_count
  );

endinterface

// File: rtl/mult_div_issue_queue_rsv_entry_wakeup.sv
// Operand wakeup for one reservation entry: captures CDB data into any pending operand
// whose tag matches the broadcast. Both operands may capture the same broadcast.
module mult_div_issue_queue_rsv_entry_wakeup
  import mult_div_issue_queue_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  queue_data entry_i,
  input  cdb_bus_t  cdb_i,
  output queue_data entry_o
);

  // Tag compare and capture for rs1 and rs2 independently.
  always_comb begin
    entry_o = entry_i;
    if (cdb_i.valid && !entry_i.rs1_data_valid &&
        entry_i.rs1_tag[TAG_W-1:0] == cdb_i.tag[TAG_W-1:0]) begin
      entry_o.rs1_data       = cdb_i.data;
      entry_o.rs1_data_valid = 1'b1;
    end
    if (cdb_i.valid && !entry_i.rs2_data_valid &&
        entry_i.rs2_tag[TAG_W-1:0] == cdb_i.tag[TAG_W-1:0]) begin
      entry_o.rs2_data       = cdb_i.data;
      entry_o.rs2_data_valid = 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_issue_queue.sv
// Reservation-station issue queue for the mult or div unit. Collapsing shift array:
// slot 0 is the oldest entry, and the lowest-index fully-ready entry issues.
// Optional feature: define MDQ_FLUSH_EN to add a 'flush' input that clears the queue.
module mult_div_issue_queue
  import mult_div_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = MDQ_DEPTH_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
`ifdef MDQ_FLUSH_EN
  input logic                    flush,
`endif
  mult_div_issue_queue_if.slave  q
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0]  count_q, count_d, tail;
  logic [DEPTH-1:0] ready_vec;
  logic             flush_w, fire, accept;
  cdb_bus_t         cdb;
  queue_data        disp_woken, sel_data;

`ifdef MDQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign cdb = '{valid: q.cdb_valid, tag: q.cdb_tag, data: q.cdb_data};

  // Fullness comes from registered count, so a same-cycle issue never admits a dispatch.
  assign q.queue_full  = (count_q == CntW'(DEPTH));
  assign q.queue_count = count_q;
  assign q.issue_valid = (|ready_vec) & ~flush_w;
  assign q.issue_data  = q.issue_valid ? sel_data : '0;

  assign fire   = q.issue_valid & q.issue_ready;
  assign accept = q.dispatch_en & ~q.queue_full & ~flush_w;
  // Write slot for a new entry after the issued entry (if any) has collapsed out.
  assign tail   = count_q - CntW'(fire);

  mult_div_issue_queue_rsv_entry_wakeup #(.TAG_W(TAG_W)) u_disp_wake (
    .entry_i (q.dispatch_data),
    .cdb_i   (cdb),
    .entry_o (disp_woken)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic      valid_q, valid_d, shift, take_new, prior_ready, up_valid;
    queue_data entry_q, entry_d, woken, up_data, pick, acc;

    mult_div_issue_queue_rsv_entry_wakeup #(.TAG_W(TAG_W)) u_wake (
      .entry_i (entry_q),
      .cdb_i   (cdb),
      .entry_o (woken)
    );

    assign ready_vec[i] = valid_q & entry_q.rs1_data_valid & entry_q.rs2_data_valid;

    // Slots at or above the issuing slot pull their younger neighbour down.
    assign shift    = fire & (|ready_vec[i:0]);
    assign take_new = accept & (tail == CntW'(i));

    if (i == 0) begin : g_first
      assign prior_ready = 1'b0;
    end else begin : g_rest
      assign prior_ready = |ready_vec[i-1:0];
    end

    if (i + 1 < DEPTH) begin : g_up
      assign up_valid = g_entry[i+1].valid_q;
      assign up_data  = g_entry[i+1].woken;
    end else begin : g_top
      assign up_valid = 1'b0;
      assign up_data  = woken;
    end

    // AND-OR priority mux: only the oldest ready slot contributes.
    assign pick = (ready_vec[i] & ~prior_ready) ? entry_q : '0;
    if (i == 0) begin : g_acc_first
      assign acc = pick;
    end else begin : g_acc_rest
      assign acc = g_entry[i-1].acc | pick;
    end

    // Slot next state: collapse, then dispatch write, with flush clearing everything.
    always_comb begin
      valid_d = shift ? up_valid : valid_q;
      entry_d = shift ? up_data  : woken;
      if (take_new) begin
        valid_d = 1'b1;
        entry_d = disp_woken;
      end
      if (flush_w) begin
        valid_d = 1'b0;
      end
    end

    // Slot state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        entry_q <= '0;
      end else begin
        valid_q <= valid_d;
        entry_q <= entry_d;
      end
    end
  end

  assign sel_data = g_entry[DEPTH-1].acc;

  // Occupancy update; issue and dispatch in the same cycle cancel out.
  always_comb begin
    count_d = count_q + CntW'(accept) - CntW'(fire);
    if (flush_w) begin
      count_d = '0;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mult_div_issue_queue.sv
// Self-checking bench for mult_div_issue_queue: expected issues are pushed to a
// scoreboard queue when dispatched/woken and popped when the DUT issues.
module tb_mult_div_issue_queue;
  import mult_div_issue_queue_pkg::*;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst;
`ifdef MDQ_FLUSH_EN
  logic flush;
`endif
  int checks = 0;
  int errors = 0;
  queue_data sb_q[$];

  always #5 clk = ~clk;

  mult_div_issue_queue_if #(.DEPTH(Depth)) dq_if ();

  mult_div_issue_queue #(.DEPTH(Depth), .TAG_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef MDQ_FLUSH_EN
    .flush (flush),
`endif
    .q     (dq_if)
  );

  function automatic queue_data mk(input logic [31:0] d1, input logic v1, input logic [5:0] t1,
                                   input logic [31:0] d2, input logic v2, input logic [5:0] t2,
                                   input logic [5:0] rd);
    queue_data r;
    r.rs1_data = d1; r.rs1_data_valid = v1; r.rs1_tag = t1;
    r.rs2_data = d2; r.rs2_data_valid = v2; r.rs2_tag = t2;
    r.rd_tag   = rd;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dq_if.dispatch_en   = 1'b0;
    dq_if.dispatch_data = '0;
    dq_if.cdb_valid     = 1'b0;
    dq_if.cdb_tag       = '0;
    dq_if.cdb_data      = '0;
  endtask

  task automatic test_reset();
    queue_data exp;
    rst = 1'b1;
    idle_inputs();
    dq_if.issue_ready = 1'b0;
`ifdef MDQ_FLUSH_EN
    flush = 1'b0;
`endif
    cyc();
    cyc();
    exp = '0;
    checks++;
    if (dq_if.queue_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", dq_if.queue_count);
    end
    checks++;
    if (dq_if.queue_full !== 1'b0) begin
      errors++; $display("FAIL reset_full got %b want 0", dq_if.queue_full);
    end
    checks++;
    if (dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL reset_issue_valid got %b want 0", dq_if.issue_valid);
    end
    checks++;
    if (dq_if.issue_data !== exp) begin
      errors++; $display("FAIL reset_issue_data got %h want 0", dq_if.issue_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    queue_data d, exp;
    dq_if.issue_ready = 1'b1;
    d = mk(32'd5, 1'b1, 6'h00, 32'd7, 1'b1, 6'h00, 6'd3);
    sb_q.push_back(d);
    dq_if.dispatch_en = 1'b1; dq_if.dispatch_data = d;
    cyc();
    dq_if.dispatch_en = 1'b0;
    checks++;
    if (dq_if.issue_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid got %b want 1", dq_if.issue_valid);
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (dq_if.issue_data !== exp) begin
        errors++; $display("FAIL single_data got %h want %h", dq_if.issue_data, exp);
      end
    end
    cyc();
    checks++;
    if (dq_if.queue_count !== 3'd0 || dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL single_empty got count %0d valid %b want 0 0",
                         dq_if.queue_count, dq_if.issue_valid);
    end
  endtask

  task automatic test_cdb_wakeup();
    queue_data d, exp;
    dq_if.issue_ready = 1'b1;
    d = mk(32'h0, 1'b0, 6'h12, 32'h22, 1'b1, 6'h01, 6'd4);
    dq_if.dispatch_en = 1'b1; dq_if.dispatch_data = d;
    cyc();
    dq_if.dispatch_en = 1'b0;
    // Non-matching broadcast must not wake the entry.
    dq_if.cdb_valid = 1'b1; dq_if.cdb_tag = 6'h13; dq_if.cdb_data = 32'hBAD0BAD0;
    checks++;
    if (dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL cdb_pending got %b want 0", dq_if.issue_valid);
    end
    cyc();
    dq_if.cdb_tag = 6'h12; dq_if.cdb_data = 32'hDEADBEEF;
    exp = d; exp.rs1_data = 32'hDEADBEEF; exp.rs1_data_valid = 1'b1;
    sb_q.push_back(exp);
    checks++;
    if (dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL cdb_no_forward got %b want 0", dq_if.issue_valid);
    end
    cyc();
    dq_if.cdb_valid = 1'b0;
    checks++;
    if (dq_if.issue_valid !== 1'b1) begin
      errors++; $display("FAIL cdb_valid got %b want 1", dq_if.issue_valid);
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (dq_if.issue_data !== exp) begin
        errors++; $display("FAIL cdb_data got %h want %h", dq_if.issue_data, exp);
      end
    end
    cyc();
  endtask

  task automatic test_dispatch_wakeup();
    queue_data d, exp;
    dq_if.issue_ready = 1'b1;
    d = mk(32'h33, 1'b1, 6'h02, 32'h0, 1'b0, 6'h09, 6'd5);
    dq_if.dispatch_en = 1'b1; dq_if.dispatch_data = d;
    dq_if.cdb_valid = 1'b1; dq_if.cdb_tag = 6'h09; dq_if.cdb_data = 32'h11;
    exp = d; exp.rs2_data = 32'h11; exp.rs2_data_valid = 1'b1;
    sb_q.push_back(exp);
    cyc();
    idle_inputs();
    checks++;
    if (dq_if.issue_valid !== 1'b1) begin
      errors++; $display("FAIL dispwake_valid got %b want 1", dq_if.issue_valid);
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (dq_if.issue_data !== exp) begin
        errors++; $display("FAIL dispwake_data got %h want %h", dq_if.issue_data, exp);
      end
    end
    cyc();
  endtask

  task automatic test_dual_wakeup();
    queue_data d, exp;
    dq_if.issue_ready = 1'b1;
    d = mk(32'h0, 1'b0, 6'h15, 32'h0, 1'b0, 6'h15, 6'd6);
    dq_if.dispatch_en = 1'b1; dq_if.dispatch_data = d;
    cyc();
    dq_if.dispatch_en = 1'b0;
    dq_if.cdb_valid = 1'b1; dq_if.cdb_tag = 6'h15; dq_if.cdb_data = 32'hCAFEF00D;
    exp = d;
    exp.rs1_data = 32'hCAFEF00D; exp.rs1_data_valid = 1'b1;
    exp.rs2_data = 32'hCAFEF00D; exp.rs2_data_valid = 1'b1;
    sb_q.push_back(exp);
    cyc();
    dq_if.cdb_valid = 1'b0;
    checks++;
    if (dq_if.issue_valid !== 1'b1) begin
      errors++; $display("FAIL dual_valid got %b want 1", dq_if.issue_valid);
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (dq_if.issue_data !== exp) begin
        errors++; $display("FAIL dual_data got %h want %h", dq_if.issue_data, exp);
      end
    end
    cyc();
  endtask

  task automatic test_full();
    queue_data ent[4];
    queue_data extra, exp;
    dq_if.issue_ready = 1'b0;
    ent[0] = mk(32'h0,  1'b0, 6'h20, 32'hA0, 1'b1, 6'h00, 6'd10);
    ent[1] = mk(32'hA1, 1'b1, 6'h00, 32'hB1, 1'b1, 6'h00, 6'd11);
    ent[2] = mk(32'hA2, 1'b1, 6'h00, 32'hB2, 1'b1, 6'h00, 6'd12);
    ent[3] = mk(32'hA3, 1'b1, 6'h00, 32'hB3, 1'b1, 6'h00, 6'd13);
    extra  = mk(32'hEE, 1'b1, 6'h00, 32'hFF, 1'b1, 6'h00, 6'd14);
    for (int k = 0; k < 4; k++) begin
      dq_if.dispatch_en = 1'b1; dq_if.dispatch_data = ent[k];
      if (k > 0) sb_q.push_back(ent[k]);
      cyc();
    end
    checks++;
    if (dq_if.queue_full !== 1'b1 || dq_if.queue_count !== 3'd4) begin
      errors++; $display("FAIL full_flag got full %b count %0d want 1 4",
                         dq_if.queue_full, dq_if.queue_count);
    end
    checks++;
    if (dq_if.issue_valid !== 1'b1 || dq_if.issue_data !== sb_q[0]) begin
      errors++; $display("FAIL full_peek got %b %h want 1 %h",
                         dq_if.issue_valid, dq_if.issue_data, sb_q[0]);
    end
    dq_if.dispatch_data = extra;
    cyc();
    checks++;
    if (dq_if.queue_count !== 3'd4) begin
      errors++; $display("FAIL full_drop got %0d want 4", dq_if.queue_count);
    end
    // Issue and dispatch together while full: the dispatch is still dropped.
    dq_if.issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dq_if.issue_valid !== 1'b1) begin
        errors++; $display("FAIL full_issue%0d_valid got %b want 1", k, dq_if.issue_valid);
      end else begin
        exp = sb_q.pop_front();
        checks++;
        if (dq_if.issue_data !== exp) begin
          errors++; $display("FAIL full_issue%0d_data got %h want %h", k, dq_if.issue_data, exp);
        end
      end
      cyc();
      dq_if.dispatch_en = 1'b0;
      if (k == 0) begin
        checks++;
        if (dq_if.queue_count !== 3'd3 || dq_if.queue_full !== 1'b0) begin
          errors++; $display("FAIL full_issue_drop got count %0d full %b want 3 0",
                             dq_if.queue_count, dq_if.queue_full);
        end
      end
    end
    checks++;
    if (dq_if.issue_valid !== 1'b0 || dq_if.queue_count !== 3'd1) begin
      errors++; $display("FAIL full_pending got valid %b count %0d want 0 1",
                         dq_if.issue_valid, dq_if.queue_count);
    end
    dq_if.cdb_valid = 1'b1; dq_if.cdb_tag = 6'h20; dq_if.cdb_data = 32'h12345678;
    exp = ent[0]; exp.rs1_data = 32'h12345678; exp.rs1_data_valid = 1'b1;
    sb_q.push_back(exp);
    cyc();
    dq_if.cdb_valid = 1'b0;
    checks++;
    if (dq_if.issue_valid !== 1'b1) begin
      errors++; $display("FAIL full_last_valid got %b want 1", dq_if.issue_valid);
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (dq_if.issue_data !== exp) begin
        errors++; $display("FAIL full_last_data got %h want %h", dq_if.issue_data, exp);
      end
    end
    cyc();
    checks++;
    if (dq_if.queue_count !== 3'd0) begin
      errors++; $display("FAIL full_drained got %0d want 0", dq_if.queue_count);
    end
  endtask

  task automatic test_back_to_back();
    queue_data d, exp;
    dq_if.issue_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        checks++;
        if (dq_if.issue_valid !== 1'b1 || dq_if.queue_count !== 3'd1 || sb_q.size() == 0) begin
          errors++; $display("FAIL b2b%0d_state got valid %b count %0d want 1 1",
                             k, dq_if.issue_valid, dq_if.queue_count);
        end else begin
          exp = sb_q.pop_front();
          checks++;
          if (dq_if.issue_data !== exp) begin
            errors++; $display("FAIL b2b%0d_data got %h want %h", k, dq_if.issue_data, exp);
          end
        end
      end
      if (k < 6) begin
        d = mk($urandom, 1'b1, 6'(k), $urandom, 1'b1, 6'(k + 8), 6'(k + 32));
        sb_q.push_back(d);
        dq_if.dispatch_en = 1'b1; dq_if.dispatch_data = d;
      end else begin
        dq_if.dispatch_en = 1'b0;
      end
      cyc();
    end
    checks++;
    if (dq_if.queue_count !== 3'd0 || sb_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain got count %0d left %0d want 0 0",
                         dq_if.queue_count, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    dq_if.issue_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dq_if.dispatch_en   = 1'b1;
      dq_if.dispatch_data = mk(32'(k), 1'b1, 6'h0, 32'h9, 1'b1, 6'h0, 6'(k));
      cyc();
    end
    dq_if.dispatch_en = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    dq_if.issue_ready = 1'b1;
    checks++;
    if (dq_if.queue_count !== 3'd0 || dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid got count %0d valid %b want 0 0",
                         dq_if.queue_count, dq_if.issue_valid);
    end
    cyc();
    cyc();
    checks++;
    if (dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_late got %b want 0", dq_if.issue_valid);
    end
  endtask

`ifdef MDQ_FLUSH_EN
  task automatic test_flush();
    dq_if.issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dq_if.dispatch_en   = 1'b1;
      dq_if.dispatch_data = mk(32'(k), 1'b1, 6'h0, 32'h5, 1'b1, 6'h0, 6'(k));
      cyc();
    end
    checks++;
    if (dq_if.queue_count !== 3'd3) begin
      errors++; $display("FAIL flush_pre got %0d want 3", dq_if.queue_count);
    end
    flush = 1'b1;
    dq_if.issue_ready = 1'b1;
    checks++;
    if (dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL flush_gate got %b want 0", dq_if.issue_valid);
    end
    cyc();
    flush = 1'b0;
    dq_if.dispatch_en = 1'b0;
    checks++;
    if (dq_if.queue_count !== 3'd0 || dq_if.issue_valid !== 1'b0) begin
      errors++; $display("FAIL flush_post got count %0d valid %b want 0 0",
                         dq_if.queue_count, dq_if.issue_valid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_cdb_wakeup();
    test_dispatch_wakeup();
    test_dual_wakeup();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef MDQ_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
